uart_core_cfg: RTL and testbench

Parametrised full-duplex UART with one transmitter, one receiver and a shared baud-tick generator, all in the single clk domain with no derived clocks.
- Adds configurable data width, optional parity, 1/2 stop bits, valid/ready TX handshake, 16x-oversampled RX with mid-bit sampling, false-start rejection, and parity/framing error reporting.
- Sits between a byte-level host (FIFO or CPU register) and the tx/rx pins.

---
 rtl/uart_cfg_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_core_cfg.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_core_cfg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared constants and state encodings for uart_core_cfg
package uart_cfg_pkg;

  localparam int PAR_NONE   = 0;
  localparam int PAR_ODD    = 1;
  localparam int PAR_EVEN   = 2;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running 16x oversample tick generator
module uart_baud_tick
  import uart_cfg_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_baud_tick: clock too slow for 16x oversampling at this baud rate");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core_cfg.sv
// rtl/uart_core_cfg.sv - full-duplex UART, parametrised framing, shared baud tick
module uart_core_cfg
  import uart_cfg_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD_FLIP  = (PARITY == PAR_ODD);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("uart_core_cfg: illegal DATA_BITS/PARITY/STOP_BITS");
    end
  endgenerate

  logic tick;

  uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  tx_state_e              tx_state_q, tx_state_d;
  logic [3:0]             tx_tick_q, tx_tick_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_bit_end;

  assign tx_bit_end = tick && (tx_tick_q == LAST_TICK);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_ready   = (tx_state_q == TX_IDLE);
    tx_done    = 1'b0;
    tx         = 1'b1;
    if (tx_state_q != TX_IDLE && tick) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ ODD_FLIP;
          tx_tick_d  = 4'd0;
          tx_bit_d   = 4'd0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_bit_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 4'd1;
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_d   = 4'd0;
            tx_state_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
          end
        end
      end
      TX_PARITY: begin
        tx = tx_par_q;
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == LAST_STOP) begin
            tx_done    = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  rx_state_e              rx_state_q, rx_state_d;
  logic                   rx_s1_q, rx_s2_q;
  logic [3:0]             rx_tick_q, rx_tick_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_ferr_q, rx_ferr_d;
  logic                   rx_sample;

  // Start bit is sampled half a bit after detect; every later bit a full bit apart.
  assign rx_sample = tick &&
                     (rx_tick_q == ((rx_state_q == RX_START) ? MID_TICK : LAST_TICK));

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rx_state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP} && tick)
      rx_tick_d = rx_sample ? 4'd0 : rx_tick_q + 4'd1;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_tick_d  = 4'd0;
          rx_bit_d   = 4'd0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_sample) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
          if (rx_bit_q == LAST_DATA) begin
            rx_bit_d   = 4'd0;
            rx_state_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_d   = rx_s2_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          rx_perr_d  = (PARITY != PAR_NONE) && ((^rx_shift_q) ^ rx_par_q ^ ODD_FLIP);
          rx_ferr_d  = !rx_s2_q;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_busy       = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_core_cfg.sv
// tb/tb_uart_core_cfg.sv - scoreboard bench for uart_core_cfg in 8N1, 8O1 and 8E1
module tb_uart_core_cfg;

  localparam int CF  = 1600000;
  localparam int BR  = 100000;
  localparam int BIT = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data [3];
  logic [7:0] rx_data [3];
  logic [2:0] tx_valid, tx_ready, tx, tx_done;
  logic [2:0] rx, rx_valid, rx_perr, rx_ferr, rx_busy;
  logic [2:0] rx_force, rx_drv;

  int   tests = 0;
  int   fails = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  // Instance g uses PARITY=g: 0 none, 1 odd, 2 even; rx loops back from tx unless forced.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      assign rx[g] = rx_force[g] ? rx_drv[g] : tx[g];
      uart_core_cfg #(
        .CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(g), .STOP_BITS(1)
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data[g]),
        .tx_valid     (tx_valid[g]),
        .tx_ready     (tx_ready[g]),
        .tx           (tx[g]),
        .tx_done      (tx_done[g]),
        .rx           (rx[g]),
        .rx_data      (rx_data[g]),
        .rx_valid     (rx_valid[g]),
        .rx_parity_err(rx_perr[g]),
        .rx_frame_err (rx_ferr[g]),
        .rx_busy      (rx_busy[g])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic good_par(input int g, input logic [7:0] d);
    return (($countones(d) % 2) == 1) ^ (g == 1);
  endfunction

  function automatic exp_t frame_exp(input int g, input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    e.d  = d;
    e.pe = (g != 0) && (p != good_par(g, d));
    e.fe = !s;
    return e;
  endfunction

  task automatic push_exp(input int g, input exp_t e);
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon_pop(input int g);
    exp_t e;
    int   n;
    n = (g == 0) ? q0.size() : (g == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL rx_unexpected inst%0d: got data %0h, expected no frame", g, rx_data[g]);
    end else begin
      case (g)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("rx_word_inst%0d", g), 32'({rx_data[g], rx_perr[g], rx_ferr[g]}), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++)
      if (rx_valid[g] === 1'b1) mon_pop(g);
  end

  task automatic send_word(input int g, input logic [7:0] d, input bit push);
    int n = 0;
    @(negedge clk);
    while (tx_ready[g] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check($sformatf("tx_ready_timeout_inst%0d", g), 32'(tx_ready[g]), 32'd1);
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    if (push) push_exp(g, frame_exp(g, d, good_par(g, d), 1'b1));
    @(negedge clk);
    tx_valid[g] = 1'b0;
    tx_data[g]  = 8'($urandom);
  endtask

  task automatic burst(input int g, input int n);
    if (g == 2) begin
      send_word(2, 8'h00, 1'b1);
      send_word(2, 8'hFF, 1'b1);
      send_word(2, 8'h3C, 1'b1);
    end
    for (int i = 0; i < n; i++) send_word(g, 8'($urandom), 1'b1);
  endtask

  task automatic drive_frame(input int g, input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    int          n;
    push_exp(g, frame_exp(g, d, p, s));
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (g != 0) begin
      bits[n] = p;
      n = n + 1;
    end
    bits[n] = s;
    n = n + 1;
    rx_force[g] = 1'b1;
    for (int i = 0; i < n; i++) begin
      rx_drv[g] = bits[i];
      repeat (BIT) @(negedge clk);
    end
    rx_drv[g] = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    rx_force[g] = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no end of run, expected finish within 60000 clk");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    int         done_at, done_cnt, n;
    for (int g = 0; g < 3; g++) tx_data[g] = 8'h00;
    tx_valid = '0;
    rx_force = '0;
    rx_drv   = '1;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++)
      check($sformatf("reset_hold_inst%0d", g),
            32'({tx[g], tx_ready[g], tx_done[g], rx_valid[g], rx_perr[g], rx_ferr[g], rx_busy[g], rx_data[g]}),
            32'({7'b1100000, 8'h00}));
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      check($sformatf("reset_state_inst%0d", g),
            32'({tx[g], tx_ready[g], tx_done[g], rx_valid[g], rx_perr[g], rx_ferr[g], rx_busy[g], rx_data[g]}),
            32'({7'b1100000, 8'h00}));

    // 8N1 0xA5 waveform on inst0: accept edge is clk 0.
    pat = {1'b1, 8'hA5, 1'b0};
    push_exp(0, frame_exp(0, 8'hA5, 1'b0, 1'b1));
    tx_data[0]  = 8'hA5;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    tx_data[0]  = 8'h3C;
    done_at  = -1;
    done_cnt = 0;
    for (int k = 0; k < 160; k++) begin
      if (k == 0)       check("tx_low_after_accept", 32'(tx[0]), 32'd0);
      if (k % 16 == 8)  check($sformatf("tx_bit%0d", k / 16), 32'(tx[0]), 32'(pat[k/16]));
      if (k == 80)      check("tx_ready_busy", 32'(tx_ready[0]), 32'd0);
      if (tx_done[0] === 1'b1) begin
        done_at = k;
        done_cnt++;
      end
      @(negedge clk);
    end
    check("tx_done_clk", 32'(done_at), 32'd159);
    check("tx_done_count", 32'(done_cnt), 32'd1);
    check("tx_ready_after", 32'(tx_ready[0]), 32'd1);
    repeat (BIT) @(negedge clk);

    fork
      burst(0, 6);
      burst(1, 6);
      burst(2, 4);
    join
    repeat (3 * BIT) @(negedge clk);

    drive_frame(1, 8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      int   g;
      logic [7:0] d;
      g = $urandom_range(0, 2);
      d = 8'($urandom);
      drive_frame(g, d, 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    rx_force[0] = 1'b1;
    rx_drv[0]   = 1'b0;
    repeat (5) @(negedge clk);
    check("false_start_busy", 32'(rx_busy[0]), 32'd1);
    rx_drv[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("false_start_idle", 32'(rx_busy[0]), 32'd0);
    rx_force[0] = 1'b0;

    push_exp(2, frame_exp(2, 8'h00, 1'b0, 1'b0));
    rx_force[2] = 1'b1;
    rx_drv[2]   = 1'b0;
    repeat (300) @(negedge clk);
    check("break_wait_high", 32'(rx_busy[2]), 32'd1);
    repeat (100) @(negedge clk);
    rx_drv[2] = 1'b1;
    repeat (40) @(negedge clk);
    check("break_released", 32'(rx_busy[2]), 32'd0);
    rx_force[2] = 1'b0;
    drive_frame(2, 8'h96, good_par(2, 8'h96), 1'b1);

    // Reset mid-frame: inst0 transmitting, inst1 receiving a held-low line.
    tx_data[0]  = 8'hC3;
    tx_valid[0] = 1'b1;
    rx_force[1] = 1'b1;
    rx_drv[1]   = 1'b0;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (69) @(negedge clk);
    check("pre_reset_tx_busy", 32'(tx_ready[0]), 32'd0);
    check("pre_reset_rx_busy", 32'(rx_busy[1]), 32'd1);
    rst       = 1'b1;
    rx_drv[1] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      check($sformatf("mid_reset_inst%0d", g), 32'({tx[g], tx_ready[g], rx_busy[g]}), 32'(3'b110));
    rst         = 1'b0;
    rx_force[1] = 1'b0;
    fork
      send_word(0, 8'h5A, 1'b1);
      send_word(1, 8'h5A, 1'b1);
      send_word(2, 8'h5A, 1'b1);
    join

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * BIT) @(negedge clk);
    check("drain_inst0", 32'(q0.size()), 32'd0);
    check("drain_inst1", 32'(q1.size()), 32'd0);
    check("drain_inst2", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
